control_seq: RTL and testbench
==============================

# control_seq

Sequential, parametrised control unit for the accumulator CPU, replacing the combinational `control` decoder and its external state register. It owns the T-state register, drives the same datapath strobes, and adds:
- a data-memory ready handshake with timeout,
- a true HALT with restart,
- a sticky bus-error state,
- a retired-instruction counter.

## Interface
Parameters:
- MEM_HS, 1, 1 = EXEC1 memory ops wait for `mem_ready`; 0 = single-cycle memory, `mem_ready` ignored
- TO_W, 4, width of wait counter; a memory op may spend at most 2^TO_W−1 cycles in EXEC1
- CNT_W, 16, width of `retired` counter

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- op  in  3  opcode from IR: 000 HALT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LOAD, 110 STORE, 111 JMP
- zero  in  1  accumulator-is-zero flag
- mem_ready  in  1  data memory completes current rd/wr this cycle
- run  in  1  restart pulse, honoured only in HALTED
- rd, wr, ld_mdr, ld_acc, ld_ir, ld_pc, ld_fla, inc, inst_ld  out  1 each  datapath strobes (combinational from state, op, zero, mem_ready)
- halted  out  1  high in HALTED
- bus_err  out  1  high in BUSERR
- state  out  4  current state encoding (debug)
- retired  out  CNT_W  count of `ld_ir` cycles, wraps

## Operation
- States: RESET, FETCH, EXEC1, EXEC2, T3, T4, HALTED, BUSERR. Unused encodings go to RESET next cycle with all strobes 0.
- Strobes default to 0. "Fetch group" means ld_ir=inst_ld=inc=1.
- Transitions:
  - RESET: no strobes → FETCH.
  - FETCH: fetch group → EXEC1.
  - EXEC1 by op:
    - HALT: no strobes → HALTED.
    - SKZ: ld_fla → EXEC2.
    - ADD/AND/XOR/LOAD: rd=ld_mdr=1, held every EXEC1 cycle.
    - STORE: wr=1, held every EXEC1 cycle.
    - Memory-op advance: to EXEC2 when MEM_HS=0 or mem_ready=1. Otherwise stay in EXEC1 and increment wcnt. If still not ready on cycle 2^TO_W−1, go to BUSERR.
    - JMP: ld_pc → EXEC2.
  - EXEC2 by op:
    - ALU ops and LOAD: ld_acc plus fetch group → EXEC1.
    - STORE: fetch group → EXEC1.
    - SKZ with zero=1: inc only → T3.
    - SKZ with zero=0: fetch group → EXEC1.
    - JMP: ld_pc and inst_ld → T3.
    - HALT: → RESET.
  - T3: SKZ: inst_ld → T4. JMP: fetch group → EXEC1. Other ops → RESET.
  - T4: SKZ: fetch group → EXEC1. Other ops → RESET.
  - HALTED: no strobes; halted=1. On run=1: fetch group → EXEC1.
  - BUSERR: no strobes; bus_err=1. Stays until rst.
- wcnt (TO_W bits) clears on every entry to EXEC1 and never wraps.
- retired increments by 1 on every cycle with ld_ir=1. It wraps from 2^CNT_W−1 to 0.

## Timing
- rst sampled on the rising edge. The next cycle has state=RESET, all strobes 0, halted=0, bus_err=0, retired=0, wcnt=0.
- rst overrides everything, including mid-wait and BUSERR.
- Strobes are Mealy and valid in the same cycle as their inputs. A state change takes effect on the next edge.
- Zero-wait memory op (MEM_HS=0, or mem_ready high in its first EXEC1 cycle): 2 cycles, EXEC1+EXEC2. Each wait cycle adds 1.
- Minimum memory-op latency after reset: RESET, FETCH, EXEC1, EXEC2, i.e. ld_acc in cycle 4.
- A mem_ready rising in the timeout cycle counts as success; ready wins over timeout.
- A run pulse outside HALTED is ignored. A run pulse held in HALTED causes exactly one restart.
- JMP takes 3 cycles; SKZ takes 2 cycles (not taken) or 4 cycles (taken).

## Test plan
- Reset then LOAD with mem_ready=1 → states RESET, FETCH, EXEC1 (rd=ld_mdr=1), EXEC2 (ld_acc=1, ld_ir=1); retired=2.
- STORE with mem_ready low 3 cycles, MEM_HS=1 → wr=1 for 4 EXEC1 cycles, then EXEC2 fetch group; bus_err=0.
- ADD with mem_ready stuck low, TO_W=4 → 15 EXEC1 cycles, then BUSERR with bus_err=1; holds until rst; rst→RESET, retired=0.
- SKZ with zero=1 → ld_fla, then inc (EXEC2), then inst_ld (T3), then fetch (T4); with zero=0 → fetch in EXEC2.
- HALT → halted=1 for 10 cycles with no strobes; run=1 → fetch group, EXEC1, halted=0.
- CNT_W=4: run 16 one-cycle ops → retired wraps 15→0; rst asserted mid-EXEC1 wait → RESET next cycle.

Source files
------------

// File: rtl/control_seq.sv
// control_seq: multi-cycle control FSM for the accumulator CPU (T-states, memory handshake with timeout, halt/restart, bus error, retired counter)
// Ports: clk/rst (sync, active-high); op/zero/mem_ready/run inputs;
//        rd, wr, ld_mdr, ld_acc, ld_ir, ld_pc, ld_fla, inc, inst_ld Mealy strobes;
//        halted, bus_err status; state (debug); retired (ld_ir cycle count, wraps).
module control_seq #(
  parameter int MEM_HS = 1,
  parameter int TO_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             run,
  output logic             rd,
  output logic             wr,
  output logic             ld_mdr,
  output logic             ld_acc,
  output logic             ld_ir,
  output logic             ld_pc,
  output logic             ld_fla,
  output logic             inc,
  output logic             inst_ld,
  output logic             halted,
  output logic             bus_err,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);
  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_EXEC1 = 4'd2;
  localparam logic [3:0] S_EXEC2 = 4'd3;
  localparam logic [3:0] S_T3 = 4'd4;
  localparam logic [3:0] S_T4 = 4'd5;
  localparam logic [3:0] S_HALTED = 4'd6;
  localparam logic [3:0] S_BUSERR = 4'd7;
  localparam logic [2:0] OP_HALT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;
  // wcnt counts completed wait cycles, so the last allowed EXEC1 cycle sees 2^TO_W-2
  localparam logic [TO_W-1:0] W_LAST = TO_W'((2 ** TO_W) - 2);
  logic [3:0] nxt;
  logic [TO_W-1:0] wcnt;
  logic fg, inc1, il1, mem_go;
  assign mem_go = (MEM_HS == 0) || mem_ready;
  assign ld_ir = fg;
  assign inc = fg | inc1;
  assign inst_ld = fg | il1;
  assign halted = state == S_HALTED;
  assign bus_err = state == S_BUSERR;
  always_comb begin
    nxt = S_RESET;
    fg = 1'b0;
    inc1 = 1'b0;
    il1 = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
    ld_mdr = 1'b0;
    ld_acc = 1'b0;
    ld_pc = 1'b0;
    ld_fla = 1'b0;
    case (state)
      S_RESET: nxt = S_FETCH;
      S_FETCH: begin
        fg = 1'b1;
        nxt = S_EXEC1;
      end
      S_EXEC1: case (op)
        OP_HALT: nxt = S_HALTED;
        OP_SKZ: begin
          ld_fla = 1'b1;
          nxt = S_EXEC2;
        end
        OP_JMP: begin
          ld_pc = 1'b1;
          nxt = S_EXEC2;
        end
        default: begin
          rd = op != OP_STORE;
          ld_mdr = op != OP_STORE;
          wr = op == OP_STORE;
          nxt = mem_go ? S_EXEC2 : (wcnt == W_LAST) ? S_BUSERR : S_EXEC1;
        end
      endcase
      S_EXEC2: case (op)
        OP_HALT: nxt = S_RESET;
        OP_SKZ: begin
          inc1 = zero;
          fg = !zero;
          nxt = zero ? S_T3 : S_EXEC1;
        end
        OP_JMP: begin
          ld_pc = 1'b1;
          il1 = 1'b1;
          nxt = S_T3;
        end
        default: begin
          ld_acc = op != OP_STORE;
          fg = 1'b1;
          nxt = S_EXEC1;
        end
      endcase
      S_T3: begin
        il1 = op == OP_SKZ;
        fg = op == OP_JMP;
        nxt = (op == OP_SKZ) ? S_T4 : (op == OP_JMP) ? S_EXEC1 : S_RESET;
      end
      S_T4: begin
        fg = op == OP_SKZ;
        nxt = (op == OP_SKZ) ? S_EXEC1 : S_RESET;
      end
      S_HALTED: begin
        fg = run;
        nxt = run ? S_EXEC1 : S_HALTED;
      end
      S_BUSERR: nxt = S_BUSERR;
      default: nxt = S_RESET;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
      wcnt <= '0;
      retired <= '0;
    end else begin
      state <= nxt;
      wcnt <= (state == S_EXEC1 && nxt == S_EXEC1) ? wcnt + 1'b1 : '0;
      retired <= retired + CNT_W'(ld_ir);
    end
  end
endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: scoreboard bench for control_seq (default instance plus a CNT_W=4, MEM_HS=0 instance)
module tb_control_seq;
  localparam logic [10:0] FG = 11'h04C, RDS = 11'h500, WRS = 11'h200, ACC = 11'h080;
  localparam logic [10:0] PC = 11'h020, FLA = 11'h010, INC = 11'h008, IL = 11'h004;
  localparam logic [10:0] HLT = 11'h002, BE = 11'h001, NONE = 11'h000;
  localparam logic [3:0] S_RESET = 0, S_FETCH = 1, S_EXEC1 = 2, S_EXEC2 = 3;
  localparam logic [3:0] S_T3 = 4, S_T4 = 5, S_HALTED = 6, S_BUSERR = 7;
  localparam logic [2:0] HALT = 0, SKZ = 1, ADD = 2, LOAD = 5, STORE = 6, JMP = 7;
  typedef struct packed {
    logic [2:0] op;
    logic z, m, r, rs;
    logic [3:0] st;
    logic [10:0] s;
  } row_t;
  logic clk = 0, rst = 1, zero = 0, mem_ready = 0, run = 0;
  logic [2:0] op = 0;
  logic rd, wr, ld_mdr, ld_acc, ld_ir, ld_pc, ld_fla, inc, inst_ld, halted, bus_err;
  logic [3:0] state;
  logic [15:0] retired;
  logic rd4, wr4, ld_mdr4, ld_acc4, ld_ir4, ld_pc4, ld_fla4, inc4, inst_ld4, halted4, bus_err4;
  logic [3:0] state4;
  logic [3:0] retired4;
  logic [14:0] q[$];
  int errors = 0, checks = 0;
  wire [14:0] obs = {state, rd, wr, ld_mdr, ld_acc, ld_ir, ld_pc, ld_fla, inc, inst_ld, halted, bus_err};
  always #5 clk = ~clk;
  control_seq dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready), .run(run),
    .rd(rd), .wr(wr), .ld_mdr(ld_mdr), .ld_acc(ld_acc), .ld_ir(ld_ir), .ld_pc(ld_pc),
    .ld_fla(ld_fla), .inc(inc), .inst_ld(inst_ld), .halted(halted), .bus_err(bus_err),
    .state(state), .retired(retired)
  );
  control_seq #(.MEM_HS(0), .TO_W(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready), .run(run),
    .rd(rd4), .wr(wr4), .ld_mdr(ld_mdr4), .ld_acc(ld_acc4), .ld_ir(ld_ir4), .ld_pc(ld_pc4),
    .ld_fla(ld_fla4), .inc(inc4), .inst_ld(inst_ld4), .halted(halted4), .bus_err(bus_err4),
    .state(state4), .retired(retired4)
  );
  function automatic row_t rw(input logic [2:0] o, input logic z, m, r, rs, input logic [3:0] st, input logic [10:0] s);
    return '{o, z, m, r, rs, st, s};
  endfunction
  task automatic drive(input row_t t);
    @(posedge clk);
    #1;
    op = t.op;
    zero = t.z;
    mem_ready = t.m;
    run = t.r;
    rst = t.rs;
    q.push_back({t.st, t.s});
    @(negedge clk);
  endtask
  task automatic test_reset_load;
    row_t t[$];
    logic [14:0] e;
    rst = 1;
    repeat (2) @(posedge clk);
    t.push_back(rw(LOAD, 0, 1, 0, 0, S_RESET, NONE));
    t.push_back(rw(LOAD, 0, 1, 0, 0, S_FETCH, FG));
    t.push_back(rw(LOAD, 0, 1, 0, 0, S_EXEC1, RDS));
    t.push_back(rw(LOAD, 0, 1, 0, 0, S_EXEC2, ACC | FG));
    foreach (t[i]) begin
      drive(t[i]);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL load[%0d] got=%h want=%h", i, obs, e); end
      if (i == 0) begin
        checks++;
        if (retired !== 0) begin errors++; $display("FAIL reset_retired got=%0d want=0", retired); end
      end
    end
  endtask
  task automatic test_store_wait;
    row_t t[$];
    logic [14:0] e;
    for (int k = 0; k < 4; k++) t.push_back(rw(STORE, 0, k == 3, 0, 0, S_EXEC1, WRS));
    t.push_back(rw(STORE, 0, 0, 0, 0, S_EXEC2, FG));
    foreach (t[i]) begin
      drive(t[i]);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL store[%0d] got=%h want=%h", i, obs, e); end
      if (i == 0) begin
        checks++;
        if (retired !== 2) begin errors++; $display("FAIL retired_after_load got=%0d want=2", retired); end
      end
    end
  endtask
  task automatic test_skz_jmp;
    row_t t[$];
    logic [14:0] e;
    t.push_back(rw(SKZ, 1, 0, 0, 0, S_EXEC1, FLA));
    t.push_back(rw(SKZ, 1, 0, 0, 0, S_EXEC2, INC));
    t.push_back(rw(SKZ, 1, 0, 0, 0, S_T3, IL));
    t.push_back(rw(SKZ, 1, 0, 0, 0, S_T4, FG));
    t.push_back(rw(SKZ, 0, 0, 0, 0, S_EXEC1, FLA));
    t.push_back(rw(SKZ, 0, 0, 0, 0, S_EXEC2, FG));
    t.push_back(rw(JMP, 0, 0, 1, 0, S_EXEC1, PC));
    t.push_back(rw(JMP, 0, 0, 1, 0, S_EXEC2, PC | IL));
    t.push_back(rw(JMP, 0, 0, 1, 0, S_T3, FG));
    foreach (t[i]) begin
      drive(t[i]);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL skz_jmp[%0d] got=%h want=%h", i, obs, e); end
    end
  endtask
  task automatic test_halt_run;
    row_t t[$];
    logic [14:0] e;
    t.push_back(rw(HALT, 0, 0, 0, 0, S_EXEC1, NONE));
    for (int k = 0; k < 10; k++) t.push_back(rw(HALT, 0, 0, 0, 0, S_HALTED, HLT));
    t.push_back(rw(ADD, 0, 1, 1, 0, S_HALTED, HLT | FG));
    t.push_back(rw(ADD, 0, 1, 1, 0, S_EXEC1, RDS));
    t.push_back(rw(ADD, 0, 1, 1, 0, S_EXEC2, ACC | FG));
    foreach (t[i]) begin
      drive(t[i]);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL halt[%0d] got=%h want=%h", i, obs, e); end
    end
  endtask
  task automatic test_timeout;
    row_t t[$];
    logic [14:0] e;
    for (int k = 0; k < 15; k++) t.push_back(rw(ADD, 0, 0, 0, 0, S_EXEC1, RDS));
    for (int k = 0; k < 3; k++) t.push_back(rw(ADD, 0, 1, 1, 0, S_BUSERR, BE));
    t.push_back(rw(ADD, 0, 0, 0, 1, S_BUSERR, BE));
    t.push_back(rw(ADD, 0, 0, 0, 0, S_RESET, NONE));
    t.push_back(rw(ADD, 0, 0, 0, 0, S_FETCH, FG));
    for (int k = 0; k < 15; k++) t.push_back(rw(ADD, 0, k == 14, 0, 0, S_EXEC1, RDS));
    t.push_back(rw(ADD, 0, 0, 0, 0, S_EXEC2, ACC | FG));
    foreach (t[i]) begin
      drive(t[i]);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL timeout[%0d] got=%h want=%h", i, obs, e); end
      if (i == 19) begin
        checks++;
        if (retired !== 0) begin errors++; $display("FAIL buserr_rst_retired got=%0d want=0", retired); end
      end
    end
  endtask
  task automatic test_wrap_rst;
    row_t t[$];
    logic [14:0] e;
    t.push_back(rw(LOAD, 0, 1, 0, 1, S_EXEC1, RDS));
    t.push_back(rw(LOAD, 0, 1, 0, 0, S_RESET, NONE));
    t.push_back(rw(LOAD, 0, 1, 0, 0, S_FETCH, FG));
    for (int k = 0; k < 15; k++) begin
      t.push_back(rw(LOAD, 0, 1, 0, 0, S_EXEC1, RDS));
      t.push_back(rw(LOAD, 0, 1, 0, 0, S_EXEC2, ACC | FG));
    end
    t.push_back(rw(STORE, 0, 0, 0, 0, S_EXEC1, WRS));
    t.push_back(rw(STORE, 0, 0, 0, 1, S_EXEC1, WRS));
    t.push_back(rw(STORE, 0, 0, 0, 0, S_RESET, NONE));
    foreach (t[i]) begin
      drive(t[i]);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL wrap[%0d] got=%h want=%h", i, obs, e); end
      if (i == 31) begin
        checks++;
        if (retired4 !== 15) begin errors++; $display("FAIL retired4_pre_wrap got=%0d want=15", retired4); end
      end
      if (i == 33) begin
        checks += 2;
        if (retired4 !== 0) begin errors++; $display("FAIL retired4_wrap got=%0d want=0", retired4); end
        if (retired !== 16) begin errors++; $display("FAIL retired16 got=%0d want=16", retired); end
      end
      if (i == 34) begin
        checks++;
        if (state4 !== S_EXEC2) begin errors++; $display("FAIL no_hs_advance got=%0d want=%0d", state4, S_EXEC2); end
      end
      if (i == 35) begin
        checks++;
        if (state4 !== S_RESET) begin errors++; $display("FAIL dut4_rst got=%0d want=%0d", state4, S_RESET); end
      end
    end
  endtask
  initial begin
    test_reset_load;
    test_store_wait;
    test_skz_jmp;
    test_halt_run;
    test_timeout;
    test_wrap_rst;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
